// File: rtl/icache_pkg.sv
// icache_pkg: shared widths, constants and FSM encoding for the instruction cache
package icache_pkg;
  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [INST_W-1:0] ZERO_WORD = '0;
  typedef logic [INST_W-1:0] inst_bus_t;
  typedef logic [ADDR_W-1:0] inst_addr_bus_t;
  typedef enum logic [1:0] {
    ICacheLookup = 2'd0,
    ICacheReq    = 2'd1,
    ICacheWait   = 2'd2
  } icache_state_t;
endpackage

// File: rtl/icache_ram.sv
// icache_ram: valid/tag/data arrays with async indexed read, sync write and sync bulk valid clear
module icache_ram
  import icache_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int TAG_W = 30 - $clog2(ENTRIES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic [$clog2(ENTRIES)-1:0] rd_idx,
  output logic                       rd_valid,
  output logic [TAG_W-1:0]           rd_tag,
  output inst_bus_t                  rd_data,
  input  logic                       we,
  input  logic [$clog2(ENTRIES)-1:0] wr_idx,
  input  logic [TAG_W-1:0]           wr_tag,
  input  inst_bus_t                  wr_data
);
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0] tag_mem [ENTRIES];
  inst_bus_t data_mem [ENTRIES];
  assign rd_valid = valid[rd_idx];
  assign rd_tag = tag_mem[rd_idx];
  assign rd_data = data_mem[rd_idx];
  always_ff @(posedge clk) begin
    if (rst) valid <= '0;
    else begin
      if (clr) valid <= '0;
      if (we) valid[wr_idx] <= 1'b1;
    end
    if (we) begin
      tag_mem[wr_idx] <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end
endmodule

// File: rtl/icache.sv
// icache: direct-mapped one-word-per-line instruction cache with single-word refill FSM
module icache
  import icache_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int TAG_W = 30 - $clog2(ENTRIES)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           romen,
  input  inst_addr_bus_t instaddr,
  output inst_bus_t      inst,
  output logic           stallreq,
  input  logic           flush,
  output logic           mem_req,
  output inst_addr_bus_t mem_addr,
  input  logic           mem_gnt,
  input  logic           mem_rvalid,
  input  inst_bus_t      mem_rdata
);
  localparam int IDX_W = $clog2(ENTRIES);
  icache_state_t state;
  logic [29:0] addr_q;
  logic rd_valid;
  logic [TAG_W-1:0] rd_tag;
  inst_bus_t rd_data;
  logic hit;
  logic lookup;
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^instaddr[1:0];
  assign lookup = state == ICacheLookup;
  assign hit = rd_valid && rd_tag == instaddr[31:IDX_W+2];
  assign stallreq = !lookup || (romen && !hit);
  assign inst = (lookup && romen && hit) ? rd_data : ZERO_WORD;
  assign mem_req = state == ICacheReq;
  assign mem_addr = {addr_q, 2'b00};
  icache_ram #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) u_ram (
    .clk(clk),
    .rst(rst),
    .clr(flush),
    .rd_idx(instaddr[IDX_W+1:2]),
    .rd_valid(rd_valid),
    .rd_tag(rd_tag),
    .rd_data(rd_data),
    .we(state == ICacheWait && mem_rvalid),
    .wr_idx(addr_q[IDX_W-1:0]),
    .wr_tag(addr_q[29:IDX_W]),
    .wr_data(mem_rdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ICacheLookup;
      addr_q <= '0;
    end else if (lookup && romen && !hit) begin
      state <= ICacheReq;
      addr_q <= instaddr[31:2];
    end else if (state == ICacheReq && mem_gnt) state <= ICacheWait;
    else if (state == ICacheWait && mem_rvalid) state <= ICacheLookup;
  end
endmodule
